packet_buffer_arbiter: RTL

//  Shares one packet_buffer_ram_driver between two write clients (Ethernet RX, UART RX) and two read clients (UART TX, packet_synth).

---
 rtl/packet_buffer_arbiter_if.sv | 33 +++
 rtl/packet_buffer_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_arbiter_if.sv
// Client-side bus of the packet buffer arbiter: two write clients and two
// read clients sharing one RAM driver. The clients drive the master modport
// and the arbiter uses the slave modport.
interface packet_buffer_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr0;
    logic [ADDR_WIDTH-1:0] wr_addr1;
    logic [DATA_WIDTH-1:0] wr_val0;
    logic [DATA_WIDTH-1:0] wr_val1;
    logic [1:0]            wr_gnt;
    logic [1:0]            rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr0;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [1:0]            rd_gnt;
    logic [1:0]            rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  addr_err;

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_val0, wr_val1,
        output rd_req, rd_addr0, rd_addr1,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, addr_err
    );

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_val0, wr_val1,
        input  rd_req, rd_addr0, rd_addr1,
        output wr_gnt, rd_gnt, rd_valid, rd_data, addr_err
    );
endinterface

// File: rtl/packet_buffer_arbiter.sv
// packet_buffer_arbiter: shares one packet buffer RAM driver between two write
// clients and two read clients. The write and read ports are arbitrated
// independently with zero added latency. Read responses are steered back to
// the issuing client by a tag pipe that matches the RAM read latency.
// Optional build macro: PB_ARB_FIXED_PRIO_EN selects fixed priority
// (client 0 always wins) instead of the default round-robin arbitration.
module packet_buffer_arbiter #(
    parameter int RAM_SIZE     = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    packet_buffer_arbiter_if.slave bus,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_val,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic                  ram_read_ready,
    input  logic [DATA_WIDTH-1:0] ram_read_out
);

    // One in-flight read: oor marks a read that never reached the RAM and
    // must be answered with zero data by the tag pipe itself.
    typedef struct packed {
        logic valid;
        logic oor;
        logic id;
    } tag_t;

    // Index 0 is the write port, index 1 the read port.
    logic [1:0] req_vec [2];
    logic [1:0] gnt_vec [2];

    assign req_vec[0] = bus.wr_req;
    assign req_vec[1] = bus.rd_req;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : arb
            logic [1:0] gnt;
`ifdef PB_ARB_FIXED_PRIO_EN
            // Fixed priority: client 0 always wins contention.
            always_comb begin
                gnt = 2'b00;
                if (!reset) begin
                    if (req_vec[gi][0]) begin
                        gnt = 2'b01;
                    end else if (req_vec[gi][1]) begin
                        gnt = 2'b10;
                    end
                end
            end
`else
            // Remembers which client was granted last; starts at client 1
            // so that client 0 wins the first contention after reset.
            logic last_reg;

            // Pointer moves only on an actual grant.
            always_ff @(posedge clk) begin
                if (reset) begin
                    last_reg <= 1'b1;
                end else if (gnt != 2'b00) begin
                    last_reg <= gnt[1];
                end
            end

            // Round-robin grant: under contention the client not granted last wins.
            always_comb begin
                gnt = 2'b00;
                if (!reset) begin
                    case (req_vec[gi])
                        2'b01:   gnt = 2'b01;
                        2'b10:   gnt = 2'b10;
                        2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
                        default: gnt = 2'b00;
                    endcase
                end
            end
`endif
            assign gnt_vec[gi] = gnt;
        end
    endgenerate

    assign bus.wr_gnt = gnt_vec[0];
    assign bus.rd_gnt = gnt_vec[1];

    // Write path: the granted client's address/data go straight to the RAM.
    logic                  wr_acc;
    logic                  wr_oor;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_val;

    assign wr_acc  = |gnt_vec[0];
    assign wr_addr = gnt_vec[0][1] ? bus.wr_addr1 : bus.wr_addr0;
    assign wr_val  = gnt_vec[0][1] ? bus.wr_val1  : bus.wr_val0;
    assign wr_oor  = 32'(wr_addr) >= 32'(RAM_SIZE);

    assign ram_write_enable = wr_acc && !wr_oor;
    assign ram_write_addr   = ram_write_enable ? wr_addr : '0;
    assign ram_write_val    = ram_write_enable ? wr_val  : '0;

    // Read path: the granted client's address goes straight to the RAM.
    logic                  rd_acc;
    logic                  rd_oor;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign rd_acc  = |gnt_vec[1];
    assign rd_addr = gnt_vec[1][1] ? bus.rd_addr1 : bus.rd_addr0;
    assign rd_oor  = 32'(rd_addr) >= 32'(RAM_SIZE);

    assign ram_read_req  = rd_acc && !rd_oor;
    assign ram_read_addr = ram_read_req ? rd_addr : '0;

    // Tag pipe: one slot per cycle of RAM read latency.
    tag_t tag_in;
    tag_t tag_out;
    tag_t tag_reg [READ_LATENCY];

    assign tag_in = '{valid: rd_acc, oor: rd_acc && rd_oor, id: gnt_vec[1][1]};

    // Shift the tag of every issued read towards the response stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    // A response is delivered only against a live tag; out-of-range reads
    // complete on their own with zero data.
    logic rd_fire;

    assign tag_out      = tag_reg[READ_LATENCY-1];
    assign rd_fire      = !reset && tag_out.valid && (tag_out.oor || ram_read_ready);
    assign bus.rd_valid = rd_fire ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rd_data  = (rd_fire && !tag_out.oor) ? ram_read_out : '0;

    // Address error pulses the cycle after any granted out-of-range op.
    logic addr_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= (wr_acc && wr_oor) || (rd_acc && rd_oor);
        end
    end

    assign bus.addr_err = addr_err_reg && !reset;

endmodule
